// File: rtl/pm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pm_ctrl_pkg
// Description : Shared types, constants and helpers for the PM control island
//               clock-source select sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pm_ctrl_pkg;

    // Widest select vector the sequencer supports; helpers return this width
    localparam int c_max_src = 16;

    // Default break-before-make timing
    localparam int c_gap_cyc_def    = 2;
    localparam int c_settle_cyc_def = 4;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_SETTLE = 2'd2
    } seq_state_t;

    // One-hot decode of idx into an n-wide field; out-of-range idx gives zero
    function automatic logic [c_max_src-1:0] onehot(input int unsigned idx,
                                                    input int unsigned n);
        logic [c_max_src-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < c_max_src; i++) begin
            res[i] = (i == idx) && (idx < n);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pm_dn_counter.sv
`default_nettype none
// ============================================================================
// Module      : pm_dn_counter
// Description : Loadable saturating down-counter with a zero flag. Used for
//               both the gap and the settle intervals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module pm_dn_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load has priority; decrement holds at zero instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pm_clk_src_sel_seq.sv
`default_nettype none
// ============================================================================
// Module      : pm_clk_src_sel_seq
// Description : Break-before-make select sequencer for N-way clock/bus muxing.
//               On a switch request it gates all legs, waits GAP_CYC cycles,
//               selects the new leg, waits SETTLE_CYC cycles, then acks.
// Revision    : 1.0 - initial release
// ============================================================================
module pm_clk_src_sel_seq
    import pm_ctrl_pkg::*;
#(
    parameter  int N_SRC      = 4,
    parameter  int GAP_CYC    = c_gap_cyc_def,
    parameter  int SETTLE_CYC = c_settle_cyc_def,
    parameter  int RST_SRC    = 0,
    localparam int IDX_W      = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [IDX_W-1:0] req_src_i,
    output logic             busy_o,
    output logic             ack_o,
    output logic             err_o,
    output logic [IDX_W-1:0] cur_src_o,
    output logic [N_SRC-1:0] sel_oh_o
);

    localparam int c_cnt_max = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0]   c_gap_load    = c_cnt_w'(GAP_CYC - 1);
    localparam logic [c_cnt_w-1:0]   c_settle_load = c_cnt_w'(SETTLE_CYC - 1);
    localparam logic [c_max_src-1:0] c_rst_oh_full = onehot(RST_SRC, N_SRC);
    localparam logic [N_SRC-1:0]     c_rst_oh      = c_rst_oh_full[N_SRC-1:0];
    localparam logic [IDX_W-1:0]     c_rst_idx     = IDX_W'(RST_SRC);

    // Reject illegal parameterisations at elaboration
    if ((N_SRC < 2) || (N_SRC > c_max_src) || (GAP_CYC < 1) ||
        (SETTLE_CYC < 1) || (RST_SRC < 0) || (RST_SRC >= N_SRC)) begin : g_bad_param
        $error("pm_clk_src_sel_seq: illegal parameter combination");
    end

    seq_state_t         r_state;
    logic [N_SRC-1:0]   r_sel_oh;
    logic [IDX_W-1:0]   r_cur_src;
    logic [IDX_W-1:0]   r_tgt;
    logic               r_busy;
    logic               r_ack;
    logic               r_err;

    logic               w_src_bad;
    logic               w_start;
    logic               w_cnt_zero;
    logic               w_cnt_load;
    logic               w_cnt_dec;
    logic [c_cnt_w-1:0] w_cnt_val;
    logic [c_max_src-1:0] w_tgt_oh_full;

    // Request classification; only meaningful while idle
    assign w_src_bad = (32'(req_src_i) >= N_SRC);
    assign w_start   = (r_state == ST_IDLE) && req_i && !w_src_bad &&
                       (req_src_i != r_cur_src);

    // Counter is loaded on entry to GAP and on the GAP->SETTLE hand-over
    assign w_cnt_load = w_start || ((r_state == ST_GAP) && w_cnt_zero);
    assign w_cnt_val  = (r_state == ST_IDLE) ? c_gap_load : c_settle_load;
    assign w_cnt_dec  = (r_state != ST_IDLE) && !w_cnt_zero;

    assign w_tgt_oh_full = onehot(32'(r_tgt), N_SRC);

    // Upper decode bits are structurally zero when fewer than 16 sources exist
    if (N_SRC < c_max_src) begin : g_oh_trim
        logic w_unused_oh_hi;
        assign w_unused_oh_hi = |w_tgt_oh_full[c_max_src-1:N_SRC];
    end

    pm_dn_counter #(
        .W (c_cnt_w)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Sequencer FSM with registered select, status and pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel_oh  <= c_rst_oh;
            r_cur_src <= c_rst_idx;
            r_tgt     <= c_rst_idx;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        if (w_src_bad) begin
                            r_err <= 1'b1;
                        end else if (req_src_i == r_cur_src) begin
                            r_ack <= 1'b1;
                        end else begin
                            r_tgt    <= req_src_i;
                            r_sel_oh <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_cnt_zero) begin
                        r_sel_oh  <= w_tgt_oh_full[N_SRC-1:0];
                        r_cur_src <= r_tgt;
                        r_state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_cnt_zero) begin
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign ack_o     = r_ack;
    assign err_o     = r_err;
    assign cur_src_o = r_cur_src;
    assign sel_oh_o  = r_sel_oh;

`ifndef SYNTHESIS
    a_sel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_sel_oh));
    a_ack_err_excl: assert property (@(posedge clk) disable iff (rst) !(r_ack && r_err));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pm_clk_src_sel_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pm_clk_src_sel_seq
// Description : Self-checking bench for pm_clk_src_sel_seq. A 4-source
//               instance is compared against an elapsed-cycle reference
//               model; a 3-source instance exercises the invalid index path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pm_clk_src_sel_seq;

    localparam int N      = 4;
    localparam int GAP    = 2;
    localparam int SETTLE = 4;
    localparam int RSTS   = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] src;
    logic       busy, ack, err;
    logic [1:0] cur;
    logic [3:0] sel;

    logic       req3;
    logic [1:0] src3;
    logic       busy3, ack3, err3;
    logic [1:0] cur3;
    logic [2:0] sel3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: committed source, target, cycles since start
    int       m_cur, m_tgt, m_d;
    bit       m_busy, m_ack, m_err;
    logic [3:0] m_sel;

    always #5 clk = ~clk;

    pm_clk_src_sel_seq #(
        .N_SRC(N), .GAP_CYC(GAP), .SETTLE_CYC(SETTLE), .RST_SRC(RSTS)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req), .req_src_i(src),
        .busy_o(busy), .ack_o(ack), .err_o(err),
        .cur_src_o(cur), .sel_oh_o(sel)
    );

    pm_clk_src_sel_seq #(
        .N_SRC(3), .GAP_CYC(GAP), .SETTLE_CYC(SETTLE), .RST_SRC(0)
    ) dut3 (
        .clk(clk), .rst(rst), .req_i(req3), .req_src_i(src3),
        .busy_o(busy3), .ack_o(ack3), .err_o(err3),
        .cur_src_o(cur3), .sel_oh_o(sel3)
    );

    function automatic void model_reset();
        m_cur  = RSTS;
        m_tgt  = RSTS;
        m_d    = 0;
        m_busy = 1'b0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        m_sel  = 4'(1 << RSTS);
    endfunction

    // Advance the model by one clock edge, given the inputs seen at that edge
    function automatic void model_edge(input logic r, input int s);
        m_ack = 1'b0;
        m_err = 1'b0;
        if (m_busy) begin
            m_d++;
            if (m_d == GAP) m_cur = m_tgt;
            if (m_d == GAP + SETTLE) begin
                m_busy = 1'b0;
                m_ack  = 1'b1;
            end
        end else if (r) begin
            if (s >= N)          m_err = 1'b1;
            else if (s == m_cur) m_ack = 1'b1;
            else begin
                m_busy = 1'b1;
                m_d    = 0;
                m_tgt  = s;
            end
        end
        m_sel = (m_busy && (m_d < GAP)) ? 4'b0000 : 4'(1 << m_cur);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(req, int'(src));
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; src = 2'd0; req3 = 1'b0; src3 = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (sel !== 4'b0001) begin n_fail++; $display("FAIL rst_sel: got %b exp 0001", sel); end
        n_tests++; if (cur !== 2'd0) begin n_fail++; $display("FAIL rst_cur: got %0d exp 0", cur); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b exp 0", ack); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", err); end
        n_tests++; if (sel3 !== 3'b001) begin n_fail++; $display("FAIL rst_sel3: got %b exp 001", sel3); end
        rst = 1'b0;
        model_reset();
        tick();
        n_tests++; if (sel !== 4'b0001 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_release: sel %b busy %b exp 0001 0", sel, busy); end
    endtask

    task automatic test_switch();
        req = 1'b1; src = 2'd2;
        tick();                                  // edge k
        req = 1'b0;
        n_tests++; if (sel !== 4'b0000) begin n_fail++; $display("FAIL sw_gap0_sel: got %b exp 0000", sel); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy: got %b exp 1", busy); end
        n_tests++; if (cur !== 2'd0) begin n_fail++; $display("FAIL sw_cur_early: got %0d exp 0", cur); end
        tick();                                  // k+1
        n_tests++; if (sel !== 4'b0000) begin n_fail++; $display("FAIL sw_gap1_sel: got %b exp 0000", sel); end
        tick();                                  // k+2
        n_tests++; if (sel !== 4'b0100) begin n_fail++; $display("FAIL sw_new_sel: got %b exp 0100", sel); end
        n_tests++; if (cur !== 2'd2) begin n_fail++; $display("FAIL sw_cur: got %0d exp 2", cur); end
        for (int i = 3; i < GAP + SETTLE; i++) begin
            tick();
            n_tests++; if (busy !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL sw_settle: cyc %0d busy %b ack %b exp 1 0", i, busy, ack); end
        end
        tick();                                  // k+6
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_busy_fall: got %b exp 0", busy); end
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL sw_ack: got %b exp 1", ack); end
        tick();
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL sw_ack_pulse: got %b exp 0", ack); end
    endtask

    task automatic test_same_src();
        req = 1'b1; src = 2'd2;
        tick();
        req = 1'b0;
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL same_ack: got %b exp 1", ack); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_busy: got %b exp 0", busy); end
        n_tests++; if (sel !== 4'b0100) begin n_fail++; $display("FAIL same_sel: got %b exp 0100", sel); end
        tick();
        n_tests++; if (ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL same_after: ack %b busy %b exp 0 0", ack, busy); end
    endtask

    task automatic test_bad_index();
        req3 = 1'b1; src3 = 2'd3;
        tick();
        req3 = 1'b0;
        n_tests++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b exp 1", err3); end
        n_tests++; if (ack3 !== 1'b0) begin n_fail++; $display("FAIL bad_ack: got %b exp 0", ack3); end
        n_tests++; if (sel3 !== 3'b001 || busy3 !== 1'b0 || cur3 !== 2'd0) begin n_fail++; $display("FAIL bad_state: sel %b busy %b cur %0d exp 001 0 0", sel3, busy3, cur3); end
        tick();
        n_tests++; if (err3 !== 1'b0 || ack3 !== 1'b0) begin n_fail++; $display("FAIL bad_pulse: err %b ack %b exp 0 0", err3, ack3); end
        n_tests++; if (sel3 !== 3'b001) begin n_fail++; $display("FAIL bad_sel_hold: got %b exp 001", sel3); end
    endtask

    task automatic test_back_to_back();
        req = 1'b1; src = 2'd1;
        tick();                                  // edge k, src 1 accepted
        src = 2'd3;                              // held request while busy
        for (int i = 1; i <= GAP + SETTLE; i++) begin
            tick();
            if (i == GAP) begin
                n_tests++; if (sel !== 4'b0010) begin n_fail++; $display("FAIL b2b_ignored: got %b exp 0010", sel); end
            end
        end
        n_tests++; if (ack !== 1'b1 || cur !== 2'd1) begin n_fail++; $display("FAIL b2b_first_ack: ack %b cur %0d exp 1 1", ack, cur); end
        tick();                                  // request in ack cycle accepted
        req = 1'b0;
        n_tests++; if (busy !== 1'b1 || sel !== 4'b0000) begin n_fail++; $display("FAIL b2b_accept: busy %b sel %b exp 1 0000", busy, sel); end
        repeat (GAP + SETTLE) tick();
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ack: got %b exp 1", ack); end
        n_tests++; if (sel !== 4'b1000 || cur !== 2'd3) begin n_fail++; $display("FAIL b2b_final: sel %b cur %0d exp 1000 3", sel, cur); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req = ($urandom_range(0, 2) == 0);
            src = 2'($urandom_range(0, N - 1));
            tick();
            n_tests++; if (sel !== m_sel) begin n_fail++; $display("FAIL rnd_sel: cyc %0d got %b exp %b", c, sel, m_sel); end
            n_tests++; if (cur !== 2'(m_cur)) begin n_fail++; $display("FAIL rnd_cur: cyc %0d got %0d exp %0d", c, cur, m_cur); end
            n_tests++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy: cyc %0d got %b exp %b", c, busy, m_busy); end
            n_tests++; if (ack !== m_ack) begin n_fail++; $display("FAIL rnd_ack: cyc %0d got %b exp %b", c, ack, m_ack); end
            n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err: cyc %0d got %b exp %b", c, err, m_err); end
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid_gap();
        for (int i = 0; i < 20 && busy; i++) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_drain: busy %b exp 0", busy); end
        req = 1'b1; src = 2'((m_cur + 1) % N);
        tick();
        req = 1'b0;
        tick();
        n_tests++; if (sel !== 4'b0000 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_gap: sel %b busy %b exp 0000 1", sel, busy); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (sel !== 4'b0001) begin n_fail++; $display("FAIL mid_async_sel: got %b exp 0001", sel); end
        n_tests++; if (cur !== 2'd0 || busy !== 1'b0 || ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_async_st: cur %0d busy %b ack %b err %b exp 0 0 0 0", cur, busy, ack, err); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++; if (ack !== 1'b0 || busy !== 1'b0 || sel !== 4'b0001) begin n_fail++; $display("FAIL mid_post: cyc %0d ack %b busy %b sel %b exp 0 0 0001", i, ack, busy, sel); end
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_same_src();
        test_bad_index();
        test_back_to_back();
        test_random();
        test_reset_mid_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
